// File: rtl/wb_syscall_unit_if.sv
// Writeback/syscall unit bus: instruction handshake, registered writeback,
// display FIFO consumer handshake and core status signals.
interface wb_syscall_unit_if #(
  parameter int DATA_W = 32,
  parameter int SIG_W  = 32,
  parameter int CNT_W  = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_pc;
  logic [SIG_W-1:0]  in_signal;
  logic [DATA_W-1:0] in_d;
  logic [DATA_W-1:0] in_r;
  logic [DATA_W-1:0] in_v0;
  logic [DATA_W-1:0] in_a0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              disp_valid;
  logic              disp_ready;
  logic [DATA_W-1:0] disp_data;
  logic              disp_is_char;
  logic [DATA_W-1:0] display;
  logic              run_en;
  logic              halted;
  logic              bad_syscall;
  logic [CNT_W-1:0]  retired;

  // Upstream pipeline plus display consumer side
  modport master (
    output in_valid, in_pc, in_signal, in_d, in_r, in_v0, in_a0, disp_ready,
    input  in_ready, out_valid, out_data, disp_valid, disp_data, disp_is_char,
           display, run_en, halted, bad_syscall, retired
  );

  // Writeback stage side
  modport slave (
    input  in_valid, in_pc, in_signal, in_d, in_r, in_v0, in_a0, disp_ready,
    output in_ready, out_valid, out_data, disp_valid, disp_data, disp_is_char,
           display, run_en, halted, bad_syscall, retired
  );
endinterface

// File: rtl/wb_syscall_unit.sv
// Final MIPS pipeline stage: writeback select/register, print/halt syscall
// service with a buffered display FIFO, run/halt control and retire counter.
module wb_syscall_unit #(
  parameter int DATA_W       = 32,
  parameter int SIG_W        = 32,
  parameter int MEMTOREG_BIT = 3,
  parameter int JAL_BIT      = 13,
  parameter int SYSCALL_BIT  = 15,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 32
) (
  input logic             Clock,
  input logic             Reset,
  wb_syscall_unit_if.slave bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]       FULL_CNT = (PW + 1)'(FIFO_DEPTH);
  localparam logic [DATA_W-1:0] V0_INT   = DATA_W'(1);
  localparam logic [DATA_W-1:0] V0_HALT  = DATA_W'(10);
  localparam logic [DATA_W-1:0] V0_CHAR  = DATA_W'(11);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]        state;
  logic [PW:0]       count;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic              fifo_char [FIFO_DEPTH];
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] display_q;
  logic              bad_q;
  logic [CNT_W-1:0]  retired_q;

  logic [DATA_W-1:0] wb_value;
  logic [DATA_W-1:0] push_value;
  logic              is_sys, is_int, is_chr, is_halt, is_print;
  logic              ready, accept, push, pop, nonempty;

  // Writeback select, syscall decode and handshake qualification
  always_comb begin
    wb_value   = bus.in_signal[JAL_BIT]      ? bus.in_pc :
                 bus.in_signal[MEMTOREG_BIT] ? bus.in_d  : bus.in_r;
    is_sys     = bus.in_signal[SYSCALL_BIT];
    is_int     = (bus.in_v0 == V0_INT);
    is_chr     = (bus.in_v0 == V0_CHAR);
    is_halt    = (bus.in_v0 == V0_HALT);
    is_print   = is_int | is_chr;
    push_value = is_chr ? {{(DATA_W-8){1'b0}}, bus.in_a0[7:0]} : bus.in_a0;
    nonempty   = (count != '0);
    // Full test deliberately uses the pre-pop count: a pop only frees a slot next cycle
    ready      = (state == ST_RUN) &
                 ~(bus.in_valid & is_sys & is_print & (count == FULL_CNT));
    accept     = bus.in_valid & ready;
    push       = accept & is_sys & is_print;
    pop        = nonempty & bus.disp_ready;
  end

  assign bus.in_ready     = ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.disp_valid   = nonempty;
  assign bus.disp_data    = nonempty ? fifo_data[rd_ptr] : '0;
  assign bus.disp_is_char = nonempty & fifo_char[rd_ptr];
  assign bus.display      = display_q;
  assign bus.run_en       = (state == ST_RUN);
  assign bus.halted       = (state == ST_HALTED);
  assign bus.bad_syscall  = bad_q;
  assign bus.retired      = retired_q;

  // Display FIFO storage; contents need no reset since outputs are gated by count
  always_ff @(posedge Clock) begin
    if (push) begin
      fifo_data[wr_ptr] <= push_value;
      fifo_char[wr_ptr] <= is_chr;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push & ~pop)      count <= count + 1'b1;
      else if (pop & ~push) count <= count - 1'b1;
    end
  end

  // Registered writeback, last print value, sticky error and retire counter
  always_ff @(posedge Clock) begin
    if (Reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      display_q   <= '0;
      bad_q       <= 1'b0;
      retired_q   <= '0;
    end else begin
      out_valid_q <= accept;
      if (accept) out_data_q <= wb_value;
      if (push) display_q <= push_value;
      if (accept & is_sys & ~is_print & ~is_halt) bad_q <= 1'b1;
      if (accept & (retired_q != '1)) retired_q <= retired_q + 1'b1;
    end
  end

  // Run/drain/halted control
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:    if (accept & is_sys & is_halt) state <= ST_DRAIN;
        ST_DRAIN:  if (!nonempty) state <= ST_HALTED;
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_syscall_unit.sv
// Randomised and directed bench for wb_syscall_unit with a scoreboard monitor.
module tb_wb_syscall_unit;

  localparam int DW    = 32;
  localparam int SW    = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] B_MEM = 32'h1 << 3;
  localparam logic [31:0] B_JAL = 32'h1 << 13;
  localparam logic [31:0] B_SYS = 32'h1 << 15;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  wb_syscall_unit_if #(.DATA_W(DW), .SIG_W(SW), .CNT_W(32)) bus ();
  wb_syscall_unit_if #(.DATA_W(DW), .SIG_W(SW), .CNT_W(3))  bus3 ();

  assign bus3.in_valid   = bus.in_valid;
  assign bus3.in_pc      = bus.in_pc;
  assign bus3.in_signal  = bus.in_signal;
  assign bus3.in_d       = bus.in_d;
  assign bus3.in_r       = bus.in_r;
  assign bus3.in_v0      = bus.in_v0;
  assign bus3.in_a0      = bus.in_a0;
  assign bus3.disp_ready = bus.disp_ready;

  wb_syscall_unit #(.DATA_W(DW), .SIG_W(SW), .MEMTOREG_BIT(3), .JAL_BIT(13),
                    .SYSCALL_BIT(15), .FIFO_DEPTH(DEPTH), .CNT_W(32))
    dut (.Clock(Clock), .Reset(Reset), .bus(bus));

  wb_syscall_unit #(.DATA_W(DW), .SIG_W(SW), .MEMTOREG_BIT(3), .JAL_BIT(13),
                    .SYSCALL_BIT(15), .FIFO_DEPTH(DEPTH), .CNT_W(3))
    dut3 (.Clock(Clock), .Reset(Reset), .bus(bus3));

  int checks = 0;
  int failures = 0;

  // Reference model state (abstract: counts, queues, run phase)
  logic [31:0] exp_out_q[$];
  logic [32:0] exp_disp_q[$];
  int          m_phase;     // 0 running, 1 waiting for FIFO to empty, 2 stopped
  int          m_cnt;
  bit          m_bad;
  longint      m_ret;
  logic [31:0] m_display;
  bit          last_acc;
  bit          rnd_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model evaluation and status checks on the falling edge
  task automatic cycle();
    logic [31:0] sig, v0, a0, wb;
    bit sys, is_print, exp_ready, acc, pop, halt_req;
    int cnt_before;
    longint sat;
    @(negedge Clock);
    if (Reset) begin
      m_phase = 0; m_cnt = 0; m_bad = 0; m_ret = 0; m_display = '0; last_acc = 0;
      exp_out_q.delete();
      exp_disp_q.delete();
    end else begin
      sig = bus.in_signal; v0 = bus.in_v0; a0 = bus.in_a0;
      sys = sig[15];
      is_print = sys && (v0 == 1 || v0 == 11);
      exp_ready = (m_phase == 0) && !(bus.in_valid && is_print && m_cnt == DEPTH);
      sat = (m_ret > 7) ? 7 : m_ret;
      chk("in_ready", bus.in_ready, exp_ready);
      chk("run_en", bus.run_en, m_phase == 0);
      chk("halted", bus.halted, m_phase == 2);
      chk("disp_valid", bus.disp_valid, m_cnt != 0);
      chk("bad_syscall", bus.bad_syscall, m_bad);
      chk("retired", bus.retired, m_ret);
      chk("retired_sat3", bus3.retired, sat);
      chk("display", bus.display, m_display);
      acc = bus.in_valid && exp_ready;
      pop = (m_cnt > 0) && bus.disp_ready;
      cnt_before = m_cnt;
      halt_req = 0;
      if (acc) begin
        wb = sig[13] ? bus.in_pc : (sig[3] ? bus.in_d : bus.in_r);
        exp_out_q.push_back(wb);
        m_ret++;
        if (sys) begin
          if (v0 == 1) begin
            exp_disp_q.push_back({1'b0, a0}); m_display = a0; m_cnt++;
          end else if (v0 == 11) begin
            exp_disp_q.push_back({1'b1, 24'h0, a0[7:0]}); m_display = {24'h0, a0[7:0]}; m_cnt++;
          end else if (v0 == 10) halt_req = 1;
          else m_bad = 1;
        end
      end
      if (pop) m_cnt--;
      if (m_phase == 0 && halt_req) m_phase = 1;
      else if (m_phase == 1 && cnt_before == 0) m_phase = 2;
      last_acc = acc;
    end
    @(posedge Clock);
    #1;
  endtask

  // Scoreboard monitor: compares whatever the DUT presents against queued expectations
  always @(negedge Clock) begin
    logic [32:0] e;
    if (!Reset) begin
      if (bus.out_valid) begin
        if (exp_out_q.size() == 0) chk("out_valid_unexpected", 1, 0);
        else chk("out_data", bus.out_data, exp_out_q.pop_front());
      end
      if (bus.disp_valid && bus.disp_ready) begin
        if (exp_disp_q.size() == 0) chk("disp_unexpected", 1, 0);
        else begin
          e = exp_disp_q.pop_front();
          chk("disp_data", bus.disp_data, e[31:0]);
          chk("disp_is_char", bus.disp_is_char, e[32]);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] sig, input logic [31:0] v0, input logic [31:0] a0,
                       input logic [31:0] d, input logic [31:0] r, input logic [31:0] pc);
    bit ok = 0;
    bus.in_signal = sig; bus.in_v0 = v0; bus.in_a0 = a0;
    bus.in_d = d; bus.in_r = r; bus.in_pc = pc; bus.in_valid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if (rnd_ready) bus.disp_ready = 1'($urandom_range(0, 1));
      cycle();
      if (last_acc) begin ok = 1; break; end
    end
    bus.in_valid = 1'b0;
    if (!ok) chk("issue_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    Reset = 1'b1; bus.in_valid = 1'b0; bus.disp_ready = 1'b0;
    cycle();
    Reset = 1'b0;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_disp_valid", bus.disp_valid, 0);
    chk("rst_disp_data", bus.disp_data, 0);
    chk("rst_display", bus.display, 0);
    chk("rst_run_en", bus.run_en, 1);
    chk("rst_halted", bus.halted, 0);
    chk("rst_bad", bus.bad_syscall, 0);
    chk("rst_retired", bus.retired, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] sig, v0;
    int k;
    bus.in_valid = 1'b0; bus.in_signal = '0; bus.in_v0 = '0; bus.in_a0 = '0;
    bus.in_d = '0; bus.in_r = '0; bus.in_pc = '0; bus.disp_ready = 1'b0;
    rnd_ready = 0;
    cycle();
    do_reset();

    // Writeback select: ALU, memory, JAL, JAL+MEMTOREG
    issue(32'h0,           0, 0, 7, 5, 32'h400010);
    issue(B_MEM,           0, 0, 7, 5, 32'h400010);
    issue(B_JAL,           0, 0, 7, 5, 32'h400010);
    issue(B_JAL | B_MEM,   0, 0, 7, 5, 32'h400010);
    idle(2);

    // Print int then char with consumer ready
    bus.disp_ready = 1'b1;
    issue(B_SYS, 1,  32'hDEADBEEF, 0, 0, 0);
    issue(B_SYS, 11, 32'h141,      0, 0, 0);
    idle(3);
    chk("display_char", bus.display, 32'h41);

    // FIFO full stall: four fill, fifth held; same-cycle pop must not release it
    bus.disp_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(B_SYS, 1, 32'h100 + i, 0, 0, 0);
    bus.in_signal = B_SYS; bus.in_v0 = 1; bus.in_a0 = 32'h104; bus.in_valid = 1'b1;
    repeat (3) cycle();
    bus.disp_ready = 1'b1;
    cycle();
    bus.disp_ready = 1'b0;
    cycle();
    chk("stall_release", bus.disp_valid, 1);
    bus.in_valid = 1'b0;
    bus.disp_ready = 1'b1;
    idle(6);

    // Halt with pending output, then drain
    bus.disp_ready = 1'b0;
    issue(B_SYS, 1,  32'hA, 0, 0, 0);
    issue(B_SYS, 11, 32'h62, 0, 0, 0);
    issue(B_SYS, 10, 0, 0, 0, 0);
    idle(3);
    bus.disp_ready = 1'b1;
    idle(4);
    chk("halt_done", bus.halted, 1);

    // Bad syscall and reset while draining
    do_reset();
    issue(B_SYS, 99, 32'h5, 0, 0, 0);
    bus.disp_ready = 1'b0;
    issue(B_SYS, 1, 32'h77, 0, 0, 0);
    issue(B_SYS, 10, 0, 0, 0, 0);
    idle(2);
    do_reset();

    // Counter saturation on the 3-bit instance
    for (int i = 0; i < 10; i++) issue(32'h0, 0, 0, 0, i, 0);
    idle(1);
    chk("sat3_stop", bus3.retired, 7);

    // Randomised mix with a random consumer
    do_reset();
    rnd_ready = 1;
    for (int i = 0; i < 300; i++) begin
      sig = $urandom & ~(B_MEM | B_JAL | B_SYS);
      if ($urandom_range(0, 3) == 0) sig |= B_JAL;
      if ($urandom_range(0, 1) == 0) sig |= B_MEM;
      if ($urandom_range(0, 1) == 0) sig |= B_SYS;
      k = $urandom_range(0, 9);
      if (k < 4) v0 = 1;
      else if (k < 7) v0 = 11;
      else if (k == 7) begin
        v0 = $urandom;
        if (v0 == 1 || v0 == 10 || v0 == 11) v0 = 99;
      end else v0 = $urandom;
      if (v0 == 10) v0 = 1;
      issue(sig, v0, $urandom, $urandom, $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        bus.disp_ready = 1'($urandom_range(0, 1));
        idle(1);
      end
    end
    issue(B_SYS, 10, 0, 0, 0, 0);
    rnd_ready = 0;
    bus.disp_ready = 1'b1;
    for (int n = 0; n < 20 && !bus.halted; n++) idle(1);
    chk("rand_halted", bus.halted, 1);
    idle(2);
    chk("out_q_drained", exp_out_q.size(), 0);
    chk("disp_q_drained", exp_disp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
